// File: rtl/q2_cpu.sv
// q2_cpu: 12-bit single-address accumulator CPU with a front panel.
// Memory and IO share one asynchronous tri-state data bus; the CPU drives
// dbus only while a write sequence (W1/W2) is in progress.
// Optional build macro Q2_STEP_EN: a deposit edge with stop held executes
// exactly one instruction instead of depositing.
module q2_cpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sw,
    inout  wire  [11:0] dbus,
    output logic [11:0] abus,
    output logic        rdm,
    output logic        wrm,
    input  logic        incp_sw,
    input  logic        dep_sw,
    input  logic        start_sw,
    input  logic        stop_sw,
    output logic        run
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_IND,
        S_EXEC,
        S_W1,
        S_W2
    } state_t;

    localparam logic [2:0] OP_LEA = 3'd0;
    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_ST  = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_JAL = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    state_t      state, state_next;

    logic [11:0] a, a_next;
    logic        c, c_next;
    logic [11:0] p, p_next;
    logic [11:0] ir, ir_next;
    logic [11:0] ea, ea_next;
    logic        run_next;
    logic [11:0] abus_next;
    logic        rdm_next, wrm_next;
    logic [11:0] dout, dout_next;
    logic        drive, drive_next;
    logic        wr_dep, wr_dep_next;

    // Panel: level registers {start, stop, dep, incp} and edge history
    logic [11:0] sw_q;
    logic [3:0]  pnl_q;
    logic [2:0]  pnl_d;
    logic        start_e, dep_e, incp_e, stop_q, step_e;

    logic [2:0]  op;
    logic [11:0] base;
    logic        halt, is_wr, is_rd;

    // Operate group, bit8=0. mc = ir[6:1]: CLA, CLC, CMA, INC, SHR, SHL
    function automatic logic [12:0] opr_micro(input logic [11:0] acc,
                                              input logic        cy,
                                              input logic [5:0]  mc);
        logic [11:0] av;
        logic        cv;
        av = acc;
        cv = cy;
        if (mc[5]) av = 12'd0;
        if (mc[4]) cv = 1'b0;
        if (mc[3]) av = ~av;
        if (mc[2]) {cv, av} = {1'b0, av} + 13'd1;
        if (mc[1] && !mc[0]) begin
            {cv, av} = {av[0], cv, av[11:1]};
        end else if (mc[0] && !mc[1]) begin
            {cv, av} = {av, cv};
        end
        return {cv, av};
    endfunction

    // Skip group, bit8=1. mc = ir[3:0]: invert, A==0, A<0, C set
    function automatic logic opr_skip(input logic [11:0] acc,
                                      input logic        cy,
                                      input logic [3:0]  mc);
        logic cond;
        cond = (mc[2] && (acc == 12'd0)) || (mc[1] && acc[11]) || (mc[0] && cy);
        return cond ^ mc[3];
    endfunction

    assign op      = ir[11:9];
    assign base    = ir[7] ? {p[11:7], ir[6:0]} : {5'b0, ir[6:0]};
    assign halt    = (op == OP_OPR) && !ir[8] && ir[7];
    assign is_wr   = (op == OP_ST) || (op == OP_JAL);
    assign is_rd   = (op == OP_LD) || (op == OP_ADD) || (op == OP_AND);

    assign stop_q  = pnl_q[2];
    assign start_e = pnl_q[3] & ~pnl_d[2];
    assign dep_e   = pnl_q[1] & ~pnl_d[1];
    assign incp_e  = pnl_q[0] & ~pnl_d[0];

`ifdef Q2_STEP_EN
    assign step_e  = dep_e & stop_q;
`else
    assign step_e  = 1'b0;
`endif

    assign dbus = drive ? dout : 12'bz;

    // Panel switches are registered once; a second register gives edges
    always_ff @(posedge clk) begin
        if (rst) begin
            pnl_q <= 4'd0;
            pnl_d <= 3'd0;
        end else begin
            pnl_q <= {start_sw, stop_sw, dep_sw, incp_sw};
            pnl_d <= {pnl_q[3], pnl_q[1], pnl_q[0]};
        end
    end

    // Switch data register, aligned with the panel level registers
    always_ff @(posedge clk) begin
        sw_q <= sw;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, register updates and bus controls for the coming cycle
    always_comb begin
        state_next  = state;
        a_next      = a;
        c_next      = c;
        p_next      = p;
        ir_next     = ir;
        ea_next     = ea;
        run_next    = run;
        abus_next   = abus;
        dout_next   = dout;
        wr_dep_next = wr_dep;
        rdm_next    = 1'b0;
        wrm_next    = 1'b0;
        drive_next  = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_next = S_FETCH;
                end else if (start_e) begin
                    if (stop_q) begin
                        p_next = sw_q;
                    end else begin
                        run_next   = 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (step_e) begin
                    state_next = S_FETCH;
                end else if (dep_e) begin
                    abus_next   = p;
                    dout_next   = sw_q;
                    wr_dep_next = 1'b1;
                    state_next  = S_W1;
                end else if (incp_e) begin
                    p_next = p + 12'd1;
                end
            end

            S_FETCH: begin
                ir_next    = dbus;
                p_next     = p + 12'd1;
                state_next = S_DECODE;
            end

            S_DECODE: begin
                ea_next   = base;
                abus_next = base;
                if (ir[8] && (op != OP_OPR)) begin
                    rdm_next   = 1'b1;
                    state_next = S_IND;
                end else if (is_wr) begin
                    dout_next   = (op == OP_ST) ? a : p;
                    wr_dep_next = 1'b0;
                    state_next  = S_W1;
                end else begin
                    rdm_next   = is_rd;
                    state_next = S_EXEC;
                end
            end

            S_IND: begin
                ea_next   = dbus;
                abus_next = dbus;
                if (is_wr) begin
                    dout_next   = (op == OP_ST) ? a : p;
                    wr_dep_next = 1'b0;
                    state_next  = S_W1;
                end else begin
                    rdm_next   = is_rd;
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                case (op)
                    OP_LEA: a_next = ea;
                    OP_LD:  a_next = dbus;
                    OP_ADD: {c_next, a_next} = {1'b0, a} + {1'b0, dbus};
                    OP_AND: a_next = a & dbus;
                    OP_JMP: p_next = ea;
                    OP_OPR: begin
                        if (ir[8]) begin
                            if (opr_skip(a, c, ir[3:0])) begin
                                p_next = p + 12'd1;
                            end
                        end else begin
                            {c_next, a_next} = opr_micro(a, c, ir[6:1]);
                        end
                    end
                    default: ;
                endcase
                if (stop_q || halt || !run) begin
                    run_next   = 1'b0;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_W1: begin
                state_next = S_W2;
            end

            S_W2: begin
                if (wr_dep) begin
                    p_next = p + 12'd1;
                end else if (op == OP_JAL) begin
                    p_next = ea + 12'd1;
                end
                if (stop_q || !run) begin
                    run_next   = 1'b0;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_FETCH;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Every fetch reads mem[P] with the freshly updated program counter
        if (state_next == S_FETCH) begin
            abus_next = p_next;
            rdm_next  = 1'b1;
        end
        // Address and data stay put across W1/W2; the strobe rises entering W2
        drive_next = (state_next == S_W1) || (state_next == S_W2);
        wrm_next   = (state_next == S_W2);
    end

    // Architectural registers and registered bus controls
    always_ff @(posedge clk) begin
        if (rst) begin
            a      <= 12'd0;
            c      <= 1'b0;
            p      <= 12'd0;
            ir     <= 12'd0;
            run    <= 1'b0;
            abus   <= 12'd0;
            rdm    <= 1'b0;
            wrm    <= 1'b0;
            drive  <= 1'b0;
            wr_dep <= 1'b0;
        end else begin
            a      <= a_next;
            c      <= c_next;
            p      <= p_next;
            ir     <= ir_next;
            run    <= run_next;
            abus   <= abus_next;
            rdm    <= rdm_next;
            wrm    <= wrm_next;
            drive  <= drive_next;
            wr_dep <= wr_dep_next;
        end
    end

    // Effective address and write data carry no reset
    always_ff @(posedge clk) begin
        ea   <= ea_next;
        dout <= dout_next;
    end

endmodule

// File: tb/tb_q2_cpu.sv
// tb_q2_cpu: directed-program bench for q2_cpu with an asynchronous
// 4096-word memory model on the shared data bus.
module tb_q2_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sw;
    wire  [11:0] dbus;
    logic [11:0] abus;
    logic        rdm, wrm;
    logic        incp_sw, dep_sw, start_sw, stop_sw;
    logic        run;

    logic [11:0] mem [0:4095];
    logic        ld_stb, clr_stb;
    logic [11:0] ld_addr, ld_data;
    logic [11:0] wr_addr, wr_data;
    int          wr_cnt   = 0;
    int          hold_err = 0;

    int n_chk  = 0;
    int n_pass = 0;

    q2_cpu dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .dbus     (dbus),
        .abus     (abus),
        .rdm      (rdm),
        .wrm      (wrm),
        .incp_sw  (incp_sw),
        .dep_sw   (dep_sw),
        .start_sw (start_sw),
        .stop_sw  (stop_sw),
        .run      (run)
    );

    always #5 clk = ~clk;

    // Memory returns data combinationally while rdm is high
    assign dbus = rdm ? mem[abus] : 12'bz;

    // Memory captures on the wrm rising edge; bench loads share this process
    always @(posedge wrm or posedge ld_stb or posedge clr_stb) begin
        if (clr_stb) begin
            for (int i = 0; i < 4096; i++) mem[i] = 12'd0;
        end else if (ld_stb) begin
            mem[ld_addr] = ld_data;
        end else begin
            wr_addr   = abus;
            wr_data   = dbus;
            mem[abus] = dbus;
            wr_cnt++;
        end
    end

    // Address and data must hold while the strobe is high
    always @(negedge clk) begin
        if (wrm && ((abus !== wr_addr) || (dbus !== wr_data))) hold_err++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic poke(input logic [11:0] ad, input logic [11:0] d);
        ld_addr = ad;
        ld_data = d;
        ld_stb  = 1'b1;
        #1;
        ld_stb  = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_cpu();
        rst = 1'b1;
        sw = 12'd0; start_sw = 1'b0; stop_sw = 1'b0; dep_sw = 1'b0; incp_sw = 1'b0;
        clr_stb = 1'b1;
        #1;
        clr_stb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse(input logic st, input logic sp, input logic dp,
                         input logic ip, input logic [11:0] v);
        sw = v; start_sw = st; stop_sw = sp; dep_sw = dp; incp_sw = ip;
        repeat (4) @(negedge clk);
        start_sw = 1'b0; stop_sw = 1'b0; dep_sw = 1'b0; incp_sw = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Start from P, count cycles with run high until it drops again
    task automatic go(input int budget, output int rcyc);
        bit seen, done;
        rcyc = 0; seen = 1'b0; done = 1'b0;
        start_sw = 1'b1;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (n == 3) start_sw = 1'b0;
            if (run) begin
                seen = 1'b1;
                rcyc++;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        start_sw = 1'b0;
        repeat (3) @(negedge clk);
        chk("halted", done, 1);
    endtask

    initial begin
        int rc;
        bit seen, done;
        ld_stb = 1'b0; clr_stb = 1'b0; ld_addr = 12'd0; ld_data = 12'd0;
        reset_cpu();

        // HLT alone: three clocks of run
        poke(12'h000, 12'hE80);
        go(50, rc);
        chk("hlt_cycles", rc, 3);
        chk("hlt_p", dut.p, 12'h001);
        chk("hlt_a", dut.a, 12'h000);

        // LD / ADD / ST / HLT
        reset_cpu();
        poke(12'h000, 12'h210);
        poke(12'h001, 12'h611);
        poke(12'h002, 12'h412);
        poke(12'h003, 12'hE80);
        poke(12'h010, 12'h7FF);
        poke(12'h011, 12'h001);
        go(100, rc);
        chk("arith_cycles", rc, 13);
        chk("st_mem", mem[12'h012], 12'h800);
        chk("add_a", dut.a, 12'h800);
        chk("add_c", dut.c, 0);
        chk("st_wr_addr", wr_addr, 12'h012);
        chk("st_wr_data", wr_data, 12'h800);
        chk("arith_p", dut.p, 12'h004);

        // Operate microcode, run in two halves
        reset_cpu();
        poke(12'h000, 12'h210);
        poke(12'h010, 12'hFFF);
        poke(12'h001, 12'hE08);
        poke(12'h002, 12'hE04);
        poke(12'h003, 12'hE80);
        poke(12'h004, 12'hE70);
        poke(12'h005, 12'hE02);
        poke(12'h006, 12'hE06);
        poke(12'h007, 12'hE80);
        go(100, rc);
        chk("shr_a", dut.a, 12'h800);
        chk("shr_c", dut.c, 0);
        chk("opr1_p", dut.p, 12'h004);
        go(100, rc);
        chk("shl_a", dut.a, 12'hFFE);
        chk("shl_c", dut.c, 1);
        chk("opr2_p", dut.p, 12'h008);

        // Reset from a dirty state
        reset_cpu();
        chk("rst_run", run, 0);
        chk("rst_abus", abus, 12'h000);
        chk("rst_rdm", rdm, 0);
        chk("rst_wrm", wrm, 0);
        chk("rst_a", dut.a, 12'h000);
        chk("rst_c", dut.c, 0);
        chk("rst_p", dut.p, 12'h000);

        // Indirect store to the IO word
        poke(12'h000, 12'h221);
        poke(12'h021, 12'h141);
        poke(12'h001, 12'h520);
        poke(12'h020, 12'hFFF);
        poke(12'h002, 12'hE80);
        go(100, rc);
        chk("ind_cycles", rc, 11);
        chk("ind_io", mem[12'hFFF], 12'h141);
        chk("ind_wr_addr", wr_addr, 12'hFFF);

        // JAL via pointer, then return through JMP I on the current page
        reset_cpu();
        poke(12'h000, 12'hA05);
        poke(12'h005, 12'hD30);
        poke(12'h030, 12'h100);
        poke(12'h101, 12'hB80);
        poke(12'h006, 12'hE80);
        go(100, rc);
        chk("jal_link", mem[12'h100], 12'h006);
        chk("jal_ret_p", dut.p, 12'h007);
        chk("jal_a", dut.a, 12'h000);

        // JAL to 0xFFF wraps P to 0; stop raised just after start
        reset_cpu();
        poke(12'h000, 12'hD31);
        poke(12'h031, 12'hFFF);
        start_sw = 1'b1;
        @(negedge clk);
        stop_sw = 1'b1;
        @(negedge clk);
        start_sw = 1'b0;
        seen = 1'b0; done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (run) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        chk("jalw_stop", done, 1);
        chk("jalw_p", dut.p, 12'h000);
        chk("jalw_link", mem[12'hFFF], 12'h001);
        stop_sw = 1'b0;
        repeat (3) @(negedge clk);

        // Skip group
        reset_cpu();
        poke(12'h000, 12'hF04);
        poke(12'h001, 12'hE80);
        poke(12'h002, 12'hE80);
        poke(12'h003, 12'hE08);
        poke(12'h004, 12'hF04);
        poke(12'h005, 12'hE80);
        poke(12'h006, 12'hF0C);
        poke(12'h007, 12'hE80);
        poke(12'h008, 12'hE80);
        poke(12'h009, 12'hE40);
        poke(12'h00A, 12'hF0C);
        poke(12'h00B, 12'hE80);
        go(100, rc);
        chk("skz_taken", dut.p, 12'h003);
        go(100, rc);
        chk("skz_not", dut.p, 12'h006);
        go(100, rc);
        chk("sknz_taken", dut.p, 12'h009);
        go(100, rc);
        chk("sknz_not", dut.p, 12'h00C);

        // Panel: load address, deposit, increment
        reset_cpu();
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 12'h800);
        chk("pnl_load_p", dut.p, 12'h800);
        chk("pnl_load_run", run, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 12'h123);
        chk("pnl_dep_mem", mem[12'h800], 12'h123);
        chk("pnl_dep_p", dut.p, 12'h801);
        chk("pnl_dep_run", run, 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        chk("pnl_incp_p", dut.p, 12'h802);

        // Tight loop; panel edges ignored while running; stop halts it
        poke(12'h040, 12'hA40);
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 12'h040);
        chk("loop_ld_p", dut.p, 12'h040);
        start_sw = 1'b1;
        repeat (4) @(negedge clk);
        start_sw = 1'b0;
        repeat (4) @(negedge clk);
        chk("loop_run", run, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        chk("loop_run_incp", run, 1);
        stop_sw = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (!run) done = 1'b1;
        end
        chk("stop_halt", done, 1);
        stop_sw = 1'b0;
        repeat (3) @(negedge clk);
        chk("stop_p", dut.p, 12'h040);

        // Reset in the middle of a write
        reset_cpu();
        poke(12'h000, 12'h412);
        start_sw = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (wrm) seen = 1'b1;
        end
        chk("midwr_seen", seen, 1);
        start_sw = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midwr_wrm", wrm, 0);
        chk("midwr_run", run, 0);
        chk("midwr_abus", abus, 12'h000);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("wr_hold", hold_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
